// File: rtl/mul_seq_trunc_pkg.sv
// Shared types for the sequential truncating multiplier.
package mul_seq_trunc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_trunc_mask.sv
// Column-truncation mask for one partial-product row of a shift-add
// multiplier. Bit i of the mask is cleared when the product column i+j
// falls below TRUNC_K and approximation is enabled.
module mul_trunc_mask #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TRUNC_K = 4,
  parameter int unsigned CW      = 4
) (
  input  logic [CW-1:0]    j_i,
  input  logic             approx_i,
  output logic [WIDTH-1:0] mask_o
);

  // Clear every multiplicand bit whose column i+j is dropped.
  always_comb begin
    mask_o = '1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (approx_i && ((i + 32'(j_i)) < TRUNC_K)) begin
        mask_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_seq_trunc.sv
// Multi-cycle unsigned shift-add multiplier with optional column truncation
// and valid/ready handshakes on input and output.
module mul_seq_trunc
  import mul_seq_trunc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TRUNC_K = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_o,
  output logic               out_approx
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            approx_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   out_q;
  logic            out_approx_q;
  logic [WIDTH-1:0] mask_w;
  logic [PW-1:0]   pp_w;

  mul_trunc_mask #(
    .WIDTH   (WIDTH),
    .TRUNC_K (TRUNC_K),
    .CW      (CW)
  ) u_mask (
    .j_i      (cnt_q),
    .approx_i (approx_q),
    .mask_o   (mask_w)
  );

  // b_q is shifted right each step, so b_q[0] is always multiplier bit cnt_q.
  assign pp_w = {{WIDTH{1'b0}}, a_q & mask_w} << cnt_q;

  // Accumulate the current row when its multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (b_q[0]) begin
      acc_d = acc_q + pp_w;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_o      = out_q;
  assign out_approx = out_approx_q;

  // Handshake FSM: accept, WIDTH accumulate steps plus one load step, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      approx_q     <= 1'b0;
      acc_q        <= '0;
      out_q        <= '0;
      out_approx_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            approx_q <= in_approx;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == CW'(WIDTH)) begin
            out_q        <= acc_q;
            out_approx_q <= approx_q;
            state_q      <= ST_DONE;
          end else begin
            acc_q <= acc_d;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_trunc.sv
// Directed bench for mul_seq_trunc: an 8-bit/K=4 instance and a 16-bit/K=0 instance.
module tb_mul_seq_trunc;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid8, in_ready8, in_approx8, out_valid8, out_ready8, out_approx8;
  logic [7:0]  in_a8, in_b8;
  logic [15:0] out8;

  logic        in_valid16, in_ready16, in_approx16, out_valid16, out_ready16, out_approx16;
  logic [15:0] in_a16, in_b16;
  logic [31:0] out16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_seq_trunc #(.WIDTH(8), .TRUNC_K(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_approx(in_approx8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_o(out8), .out_approx(out_approx8)
  );

  mul_seq_trunc #(.WIDTH(16), .TRUNC_K(0)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .in_approx(in_approx16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_o(out16), .out_approx(out_approx16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one operand pair, then count edges until out_valid (bounded).
  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic ap, output int lat);
    @(negedge clk);
    in_a8 = a; in_b8 = b; in_approx8 = ap; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_a8 = ~a; in_b8 = ~b; in_approx8 = ~ap;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release8();
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
  endtask

  task automatic txn16(input logic [15:0] a, input logic [15:0] b, input logic ap, output int lat);
    @(negedge clk);
    in_a16 = a; in_b16 = b; in_approx16 = ap; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk); #1;
    in_valid16 = 1'b0; in_a16 = ~a; in_b16 = ~b; in_approx16 = ~ap;
    lat = 0;
    while (!out_valid16 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release16();
    @(negedge clk); out_ready16 = 1'b1;
    @(posedge clk); #1; out_ready16 = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0]  ra, rb;
    logic [15:0] sa, sb;

    rst = 1'b1;
    in_valid8 = 0; in_a8 = 0; in_b8 = 0; in_approx8 = 0; out_ready8 = 0;
    in_valid16 = 0; in_a16 = 0; in_b16 = 0; in_approx16 = 0; out_ready16 = 0;
    #12;
    chk("rst_in_ready8", in_ready8, 1);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_out8", out8, 0);
    chk("rst_out_approx8", out_approx8, 0);
    chk("rst_in_ready16", in_ready16, 1);
    chk("rst_out_valid16", out_valid16, 0);
    chk("rst_out16", out16, 0);
    @(negedge clk); rst = 1'b0;

    // Exact 255*255
    chk("idle_ready_a", in_ready8, 1);
    txn8(8'd255, 8'd255, 1'b0, lat);
    chk("exact_lat", lat, 9);
    chk("exact_255x255", out8, 65025);
    chk("exact_approx_flag", out_approx8, 0);
    release8();
    chk("exact_rel_valid", out_valid8, 0);
    chk("exact_rel_ready", in_ready8, 1);

    // Approx 255*255: columns 0..3 contribute 1+4+12+32 = 49
    txn8(8'd255, 8'd255, 1'b1, lat);
    chk("approx_lat", lat, 9);
    chk("approx_255x255", out8, 64976);
    chk("approx_flag", out_approx8, 1);
    release8();

    txn8(8'd0, 8'd200, 1'b1, lat);
    chk("approx_0x200", out8, 0);
    release8();
    txn8(8'd3, 8'd1, 1'b1, lat);
    chk("approx_3x1", out8, 0);
    release8();
    txn8(8'd16, 8'd1, 1'b1, lat);
    chk("approx_col4_kept", out8, 16);
    release8();
    txn8(8'd8, 8'd1, 1'b1, lat);
    chk("approx_col3_dropped", out8, 0);
    release8();
    txn8(8'd15, 8'd15, 1'b1, lat);
    chk("approx_15x15", out8, 176);
    release8();

    // Reset while BUSY at cnt=3
    @(negedge clk);
    in_a8 = 8'd200; in_b8 = 8'd200; in_approx8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1; in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready8, 1);
    chk("midrst_out_valid", out_valid8, 0);
    chk("midrst_out", out8, 0);
    chk("midrst_out_approx", out_approx8, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid8) seen++;
    end
    chk("midrst_no_output", seen, 0);
    txn8(8'd7, 8'd9, 1'b0, lat);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_7x9", out8, 63);
    release8();

    // Backpressure with ignored in_valid pulses
    txn8(8'd12, 8'd13, 1'b0, lat);
    chk("bp_first", out8, 156);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid8 = i[0]; in_a8 = 8'(i); in_b8 = 8'd99; in_approx8 = 1'b1;
      @(posedge clk); #1;
      chk("bp_out", out8, 156);
      chk("bp_valid", out_valid8, 1);
      chk("bp_ready", in_ready8, 0);
      chk("bp_approx", out_approx8, 0);
    end
    @(negedge clk); in_valid8 = 1'b0;
    release8();
    chk("bp_rel_ready", in_ready8, 1);
    chk("bp_rel_valid", out_valid8, 0);

    // Random exact sweep, 8-bit
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      txn8(ra, rb, 1'b0, lat);
      chk("rnd8_lat", lat, 9);
      chk("rnd8_prod", out8, 64'(ra) * 64'(rb));
      release8();
    end

    // 16-bit, TRUNC_K=0: approx equals exact
    txn16(16'hFFFF, 16'hFFFF, 1'b1, lat);
    chk("w16_lat", lat, 17);
    chk("w16_max", out16, 64'd4294836225);
    chk("w16_approx_flag", out_approx16, 1);
    release16();
    for (int i = 0; i < 3; i++) begin
      sa = 16'($urandom_range(0, 65535));
      sb = 16'($urandom_range(0, 65535));
      txn16(sa, sb, 1'b0, lat);
      chk("rnd16_prod", out16, 64'(sa) * 64'(sb));
      release16();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
